// File: rtl/palette_pkg.sv
// Shared constants and types for the palette lookup: default palette, channel
// slice positions and the 8-bit {R,G,B} colour struct.
package palette_pkg;

  localparam int DEFAULT_DEPTH = 8;

  localparam logic [0:DEFAULT_DEPTH-1][23:0] DEFAULT_PALETTE = {
    24'h000000, 24'h000000, 24'h00821a, 24'h06a300,
    24'h38d979, 24'h75ffd6, 24'h52dea1, 24'h000000
  };

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb8_t;

  // Channel slice positions inside a {R,G,B} word of 3*ch_w bits.
  function automatic int r_hi(int ch_w); return 3 * ch_w - 1; endfunction
  function automatic int r_lo(int ch_w); return 2 * ch_w;     endfunction
  function automatic int g_hi(int ch_w); return 2 * ch_w - 1; endfunction
  function automatic int g_lo(int ch_w); return ch_w;         endfunction
  function automatic int b_hi(int ch_w); return ch_w - 1;     endfunction
  function automatic int b_lo(int ch_w); return 0 * ch_w;     endfunction

  function automatic logic [23:0] default_entry(int unsigned idx);
    logic [2:0] sel;
    sel = idx[2:0];
    return (idx < DEFAULT_DEPTH) ? DEFAULT_PALETTE[sel] : 24'h000000;
  endfunction

endpackage

// File: rtl/palette_lut_if.sv
// Palette write port and pixel stream bundle; master drives pixels and writes,
// slave is the lookup pipeline.
interface palette_lut_if #(
  parameter int IDX_W = 3,
  parameter int CH_W  = 8
);
  logic                wr_en;
  logic [IDX_W-1:0]    wr_addr;
  logic [3*CH_W-1:0]   wr_data;
  logic                pix_valid_in;
  logic [IDX_W-1:0]    pix_idx;
  logic                pix_valid_out;
  logic [3*CH_W-1:0]   color_out;
  logic                transp_out;

  modport master (
    output wr_en, wr_addr, wr_data, pix_valid_in, pix_idx,
    input  pix_valid_out, color_out, transp_out
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, pix_valid_in, pix_idx,
    output pix_valid_out, color_out, transp_out
  );
endinterface

// File: rtl/palette_ram.sv
// Palette storage: synchronous write, registered read returning the old entry
// on a same-address write, defaults reloaded on reset.
module palette_ram
  import palette_pkg::*;
#(
  parameter int IDX_W         = 3,
  parameter int W             = 24,
  parameter bit LOAD_DEFAULTS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [W-1:0]     wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [W-1:0]     rd_data
);
  localparam int DEPTH = 2 ** IDX_W;

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array is reset entry by entry so defaults reload on every reset;
  // this makes it a register file rather than an inferred block RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= LOAD_DEFAULTS ? W'(default_entry(i)) : '0;
      end
    end else begin
      // NOTE: non-blocking assignments give read-before-write ordering for free.
      rd_data <= mem[rd_addr];
      if (wr_en) mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/palette_lut.sv
// Two-stage palette lookup with index transparency, R/B swap and, when
// PALETTE_FADE_EN is defined, a per-channel right-shift fade.
module palette_lut
  import palette_pkg::*;
#(
  parameter int IDX_W      = 3,
  parameter int CH_W       = 8,
  parameter int TRANSP_IDX = 0
) (
  input  logic              clk,
  input  logic              rst,
  palette_lut_if.slave      bus,
  input  logic              swap_rb,
  input  logic [3*CH_W-1:0] bg_color
`ifdef PALETTE_FADE_EN
  ,
  input  logic [2:0]        fade_shift
`endif
);
  localparam int R_HI = r_hi(CH_W);
  localparam int R_LO = r_lo(CH_W);
  localparam int G_HI = g_hi(CH_W);
  localparam int G_LO = g_lo(CH_W);
  localparam int B_HI = b_hi(CH_W);
  localparam int B_LO = b_lo(CH_W);

  logic [3*CH_W-1:0] s1_entry;
  logic              s1_valid;
  logic              s1_transp;
  logic [3*CH_W-1:0] sel_color;
  logic [3*CH_W-1:0] swap_color;
  logic [3*CH_W-1:0] final_color;

  palette_ram #(
    .IDX_W         (IDX_W),
    .W             (3 * CH_W),
    .LOAD_DEFAULTS (CH_W == 8)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (bus.wr_en),
    .wr_addr (bus.wr_addr),
    .wr_data (bus.wr_data),
    .rd_addr (bus.pix_idx),
    .rd_data (s1_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_transp <= 1'b0;
    end else begin
      s1_valid  <= bus.pix_valid_in;
      s1_transp <= (bus.pix_idx == IDX_W'(TRANSP_IDX));
    end
  end

  // NOTE: every always_comb output gets a value on every path, so no latches.
  always_comb begin
    sel_color   = s1_transp ? bg_color : s1_entry;
    swap_color  = swap_rb ? {sel_color[B_HI:B_LO], sel_color[G_HI:G_LO], sel_color[R_HI:R_LO]}
                          : sel_color;
`ifdef PALETTE_FADE_EN
    final_color = {swap_color[R_HI:R_LO] >> fade_shift,
                   swap_color[G_HI:G_LO] >> fade_shift,
                   swap_color[B_HI:B_LO] >> fade_shift};
`else
    final_color = swap_color;
`endif
  end

  // Colour and transparency hold their last value across invalid cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.pix_valid_out <= 1'b0;
      bus.color_out     <= '0;
      bus.transp_out    <= 1'b0;
    end else begin
      bus.pix_valid_out <= s1_valid;
      if (s1_valid) begin
        bus.color_out  <= final_color;
        bus.transp_out <= s1_transp;
      end
    end
  end

endmodule
